// File: rtl/multicycle_issue.sv
// multicycle_issue
// Issue stage in front of the multicycle execution unit. Fetches an 8-bit
// instruction word from a synchronous ROM, decodes the opcode nibble, reads
// up to two operand registers, presents the instruction until the unit
// pulses its completion trigger, then writes the result back and advances
// the program counter.
//
// Ports:
//   clock, reset                    clock (rising edge), sync active-low reset
//   run                             level enable for fetching new instructions
//   instr_addr / instr_data         ROM address (PC) and data (1-cycle latency)
//   reg_sel_a/b, reg_data_a/b       register-file read selects and data
//   operand_a/b                     latched operands to the execution unit
//   output_to_multicycle_opcode     instruction to the unit (8'h00 = no-op)
//   opcode_next_instruction_trigger completion pulse from the unit
//   output_from_multicycle_opcode   result from the unit
//   wb_en, wb_sel, wb_data          one-cycle register write port
//   busy, halted                    registered state decodes
//   error                           00 none, 01 illegal opcode, 10 timeout
module multicycle_issue #(
  parameter int ADDR_W     = 4,
  parameter int START_ADDR = 0,
  parameter int MAX_WAIT   = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [7:0]        instr_data,
  output logic [1:0]        reg_sel_a,
  output logic [1:0]        reg_sel_b,
  input  logic [7:0]        reg_data_a,
  input  logic [7:0]        reg_data_b,
  output logic [7:0]        operand_a,
  output logic [7:0]        operand_b,
  output logic [7:0]        output_to_multicycle_opcode,
  input  logic              opcode_next_instruction_trigger,
  input  logic [7:0]        output_from_multicycle_opcode,
  output logic              wb_en,
  output logic [1:0]        wb_sel,
  output logic [7:0]        wb_data,
  output logic              busy,
  output logic              halted,
  output logic [1:0]        error
);

  // Counter only needs to reach MAX_WAIT-1; the terminal WAIT cycle halts.
  localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_READ, S_ISSUE, S_WAIT, S_WB, S_HALT
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        ir;
  logic [CNT_W-1:0]  wait_cnt;
  logic              wait_done;

  assign wait_done = (wait_cnt == CNT_W'(MAX_WAIT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (run) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        // ROM data is valid this cycle, so decode it directly.
        case (instr_data[7:4])
          4'h1, 4'h2, 4'h3, 4'h4: state_nxt = S_READ;
          4'h5:                   state_nxt = S_ISSUE;
          default:                state_nxt = S_HALT;
        endcase
      end
      S_READ:   state_nxt = S_ISSUE;
      S_ISSUE:  state_nxt = opcode_next_instruction_trigger ? S_WB : S_WAIT;
      S_WAIT: begin
        if (opcode_next_instruction_trigger) state_nxt = S_WB;
        else if (wait_done)                  state_nxt = S_HALT;
      end
      S_WB:     state_nxt = run ? S_FETCH : S_IDLE;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      halted <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy   <= !(state_nxt == S_IDLE || state_nxt == S_HALT);
      halted <= (state_nxt == S_HALT);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc        <= ADDR_W'(START_ADDR);
      ir        <= 8'h00;
      operand_a <= 8'h00;
      operand_b <= 8'h00;
      wb_data   <= 8'h00;
      error     <= 2'b00;
      wait_cnt  <= '0;
    end else begin
      case (state)
        S_DECODE: begin
          ir <= instr_data;
          // Opcode 5 takes no operands; make sure stale ones are not issued.
          if (instr_data[7:4] == 4'h5) begin
            operand_a <= 8'h00;
            operand_b <= 8'h00;
          end
          if (instr_data[7:4] > 4'h5) error <= 2'b01;
        end
        S_READ: begin
          operand_a <= reg_data_a;
          operand_b <= reg_data_b;
        end
        S_ISSUE: begin
          wait_cnt <= '0;
          if (opcode_next_instruction_trigger) wb_data <= output_from_multicycle_opcode;
        end
        S_WAIT: begin
          if (opcode_next_instruction_trigger) wb_data <= output_from_multicycle_opcode;
          else if (wait_done)                  error   <= 2'b10;
          else                                 wait_cnt <= wait_cnt + 1'b1;
        end
        S_WB:    pc <= pc + 1'b1;
        default: ;
      endcase
    end
  end

  assign instr_addr = pc;
  assign reg_sel_a  = (state == S_READ) ? ir[3:2] : 2'b00;
  assign reg_sel_b  = (state == S_READ) ? ir[1:0] : 2'b00;
  assign output_to_multicycle_opcode =
    (state == S_ISSUE || state == S_WAIT) ? ir : 8'h00;
  assign wb_en  = (state == S_WB);
  // Opcode 5 always writes register A.
  assign wb_sel = (state == S_WB && ir[7:4] != 4'h5) ? ir[3:2] : 2'b00;

endmodule

// File: tb/tb_multicycle_issue.sv
// tb_multicycle_issue
// Directed bench for multicycle_issue: ROM and register file modelled in the
// bench, execution-unit handshake driven by tasks, expected values hand
// computed from the instruction encodings.
module tb_multicycle_issue;
  localparam int ADDR_W = 2;

  logic              clock = 1'b0;
  logic              reset, run, trig;
  logic [ADDR_W-1:0] instr_addr;
  logic [7:0]        instr_data;
  logic [1:0]        reg_sel_a, reg_sel_b, wb_sel, error;
  logic [7:0]        reg_data_a, reg_data_b, operand_a, operand_b;
  logic [7:0]        op_out, result, wb_data;
  logic              wb_en, busy, halted;

  logic [7:0] rom  [4];
  logic [7:0] regs [4];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  always @(posedge clock) instr_data <= rom[instr_addr];
  assign reg_data_a = regs[reg_sel_a];
  assign reg_data_b = regs[reg_sel_b];

  multicycle_issue #(.ADDR_W(ADDR_W), .START_ADDR(0), .MAX_WAIT(8)) dut (
    .clock(clock), .reset(reset), .run(run),
    .instr_addr(instr_addr), .instr_data(instr_data),
    .reg_sel_a(reg_sel_a), .reg_sel_b(reg_sel_b),
    .reg_data_a(reg_data_a), .reg_data_b(reg_data_b),
    .operand_a(operand_a), .operand_b(operand_b),
    .output_to_multicycle_opcode(op_out),
    .opcode_next_instruction_trigger(trig),
    .output_from_multicycle_opcode(result),
    .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
    .busy(busy), .halted(halted), .error(error)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_issue();
    for (int i = 0; i < 20 && op_out == 8'h00; i++) tick();
  endtask

  // One instruction: checks issue contents, waits dly cycles, triggers,
  // checks the writeback strobe and the PC advance.
  task automatic run_instr(input logic [7:0] ir, input logic [ADDR_W-1:0] pc,
                           input logic [7:0] ea, input logic [7:0] eb,
                           input logic [7:0] res, input int dly,
                           input logic [1:0] sel, input logic drop);
    logic [ADDR_W-1:0] pc_next;
    pc_next = pc + 1'b1;
    wait_issue();
    check("issue_ir", int'(op_out), int'(ir));
    check("issue_pc", int'(instr_addr), int'(pc));
    check("issue_op_a", int'(operand_a), int'(ea));
    check("issue_op_b", int'(operand_b), int'(eb));
    check("issue_busy", int'(busy), 1);
    repeat (dly) tick();
    if (dly > 0) begin
      check("hold_ir", int'(op_out), int'(ir));
      check("hold_op_a", int'(operand_a), int'(ea));
      check("hold_op_b", int'(operand_b), int'(eb));
    end
    if (drop) run = 1'b0;
    trig   = 1'b1;
    result = res;
    tick();
    trig = 1'b0;
    check("wb_en", int'(wb_en), 1);
    check("wb_sel", int'(wb_sel), int'(sel));
    check("wb_data", int'(wb_data), int'(res));
    check("wb_nop", int'(op_out), 0);
    tick();
    check("wb_pulse", int'(wb_en), 0);
    check("pc_inc", int'(instr_addr), int'(pc_next));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic seen;
    reset  = 1'b0;
    run    = 1'b0;
    trig   = 1'b0;
    result = 8'h00;
    regs[0] = 8'h11; regs[1] = 8'h03; regs[2] = 8'h05; regs[3] = 8'h40;

    // Basic multiply
    rom[0] = 8'h26; rom[1] = 8'h00; rom[2] = 8'h00; rom[3] = 8'h00;
    do_reset();
    check("rst_busy", int'(busy), 0);
    check("rst_halted", int'(halted), 0);
    check("rst_error", int'(error), 0);
    check("rst_pc", int'(instr_addr), 0);
    check("rst_op", int'(op_out), 0);
    check("rst_wb_en", int'(wb_en), 0);
    check("rst_op_a", int'(operand_a), 0);
    run = 1'b1;
    run_instr(8'h26, 2'd0, 8'h03, 8'h05, 8'h0F, 4, 2'd1, 1'b0);

    // Operand-free opcode followed by halt
    rom[0] = 8'h5A; rom[1] = 8'h00;
    do_reset();
    run_instr(8'h5A, 2'd0, 8'h00, 8'h00, 8'h07, 0, 2'd0, 1'b0);
    n = 0;
    while (!halted && n < 20) begin tick(); n++; end
    check("halt_flag", int'(halted), 1);
    check("halt_error", int'(error), 0);
    check("halt_pc", int'(instr_addr), 1);
    check("halt_busy", int'(busy), 0);

    // Illegal opcode
    rom[0] = 8'h9F;
    do_reset();
    n = 0;
    seen = 1'b0;
    while (!halted && n < 20) begin
      tick();
      n++;
      if (op_out != 8'h00 || wb_en) seen = 1'b1;
    end
    check("ill_cycles", n, 3);
    check("ill_error", int'(error), 1);
    check("ill_activity", int'(seen), 0);
    check("ill_pc", int'(instr_addr), 0);
    run = 1'b0;
    repeat (3) tick();
    check("ill_absorb", int'(halted), 1);
    check("ill_busy", int'(busy), 0);

    // Timeout
    rom[0] = 8'h11;
    do_reset();
    run = 1'b1;
    wait_issue();
    check("to_ir", int'(op_out), 8'h11);
    n = 0;
    seen = 1'b0;
    while (!halted && n < 30) begin
      tick();
      n++;
      if (wb_en) seen = 1'b1;
    end
    check("to_cycles", n, 9);
    check("to_error", int'(error), 2);
    check("to_wb", int'(seen), 0);
    check("to_pc", int'(instr_addr), 0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("to_rst_error", int'(error), 0);
    check("to_rst_halted", int'(halted), 0);
    check("to_rst_busy", int'(busy), 0);

    // Wrap with run held, then drop run during WAIT of ROM[1]
    rom[0] = 8'h26; rom[1] = 8'h5A; rom[2] = 8'h31; rom[3] = 8'h4E;
    run = 1'b0;
    do_reset();
    run = 1'b1;
    run_instr(8'h26, 2'd0, 8'h03, 8'h05, 8'h21, 2, 2'd1, 1'b0);
    run_instr(8'h5A, 2'd1, 8'h00, 8'h00, 8'h22, 1, 2'd0, 1'b0);
    run_instr(8'h31, 2'd2, 8'h11, 8'h03, 8'h23, 0, 2'd0, 1'b0);
    run_instr(8'h4E, 2'd3, 8'h40, 8'h05, 8'h24, 3, 2'd3, 1'b0);
    run_instr(8'h26, 2'd0, 8'h03, 8'h05, 8'h25, 0, 2'd1, 1'b0);
    run_instr(8'h5A, 2'd1, 8'h00, 8'h00, 8'h26, 2, 2'd0, 1'b1);
    check("drop_busy", int'(busy), 0);
    repeat (2) tick();
    check("drop_idle_pc", int'(instr_addr), 2);
    check("drop_idle_busy", int'(busy), 0);

    // Reset in WAIT with a simultaneous trigger
    run = 1'b1;
    wait_issue();
    check("rw_ir", int'(op_out), 8'h31);
    tick();
    tick();
    reset  = 1'b0;
    trig   = 1'b1;
    result = 8'hAA;
    run    = 1'b0;
    tick();
    check("rw_wb_en", int'(wb_en), 0);
    check("rw_busy", int'(busy), 0);
    check("rw_pc", int'(instr_addr), 0);
    check("rw_op", int'(op_out), 0);
    check("rw_wb_data", int'(wb_data), 0);
    reset = 1'b1;
    trig  = 1'b0;
    tick();
    check("rw_wb_after", int'(wb_en), 0);
    check("rw_idle", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_issue.md
# multicycle_issue

Upstream issue stage for the multicycle execution unit (`opcodemulticycle`). It fetches 8-bit multicycle instruction words from a synchronous instruction ROM and decodes the opcode nibble. It reads the two operand registers selected by c4c5/c6c7 and presents the instruction to the execution unit, holding it until the unit pulses `opcode_next_instruction_trigger`. It then writes the unit's result back to the register file and advances its program counter.

## Interface
Parameters:
- `ADDR_W`, 4: instruction address width; PC wraps modulo 2^ADDR_W.
- `START_ADDR`, 0: PC value after reset.
- `MAX_WAIT`, 255: maximum cycles in WAIT before a timeout error (≥1).

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `run`  in  1  level; enables fetching of new instructions.
- `instr_addr`  out  ADDR_W  ROM address (the PC).
- `instr_data`  in  8  ROM data, valid one cycle after `instr_addr`.
- `reg_sel_a`, `reg_sel_b`  out  2  register-file read selects (A=0..D=3).
- `reg_data_a`, `reg_data_b`  in  8  combinational register-file read data.
- `operand_a`, `operand_b`  out  8  latched operands to the execution unit.
- `output_to_multicycle_opcode`  out  8  instruction to the execution unit.
- `opcode_next_instruction_trigger`  in  1  completion pulse from the execution unit.
- `output_from_multicycle_opcode`  in  8  result from the execution unit.
- `wb_en`  out  1  one-cycle register write strobe.
- `wb_sel`  out  2  write destination.
- `wb_data`  out  8  write data.
- `busy`  out  1  high in every state except IDLE and HALT.
- `halted`  out  1  high in HALT.
- `error`  out  2  00 none, 01 illegal opcode, 10 timeout.

## Operation
- States: IDLE, FETCH, DECODE, READ, ISSUE, WAIT, WB, HALT.
- **IDLE:** leave to FETCH when `run`=1; otherwise stay.
- **FETCH:** `instr_addr`=PC is driven continuously. Go to DECODE.
- **DECODE:** latch `instr_data` into the instruction register (IR). Decode IR[7:4]:
  - 0000 → HALT, `error`=00.
  - 0001–0100 → READ.
  - 0101 → ISSUE. No operands are read; `operand_a` and `operand_b` are 0.
  - 0110–1111 → HALT, `error`=01.
- **READ:** `reg_sel_a`=IR[3:2], `reg_sel_b`=IR[1:0]. Latch `reg_data_a` and `reg_data_b` into the operands. Go to ISSUE.
- **ISSUE / WAIT:** `output_to_multicycle_opcode`=IR. Operands are held stable. ISSUE lasts one cycle, then the block enters WAIT.
  - A trigger sampled high in ISSUE or WAIT captures `output_from_multicycle_opcode` into `wb_data` and moves to WB.
  - Outside ISSUE and WAIT, `output_to_multicycle_opcode`=8'h00, which the execution unit treats as a no-op, and the trigger is ignored.
- **WB:** `wb_en`=1 for exactly one cycle.
  - `wb_sel`=IR[3:2] for opcodes 0001–0100.
  - `wb_sel`=2'b00 (register A) for 0101.
  - PC is incremented, wrapping from 2^ADDR_W−1 to 0.
  - Next state is FETCH if `run`=1, else IDLE.
- **run deassertion:** deasserting `run` mid-instruction does not abort it. The current instruction completes through WB, then the block goes to IDLE.
- **Timeout:** a counter clears on entering WAIT and increments in each WAIT cycle without a trigger. When it reaches MAX_WAIT, go to HALT with `error`=10; there is no writeback.
- **HALT:** absorbing state. Only `reset` exits it. PC holds the address of the halting instruction.
- **Reset values (`reset`=0 at a clock edge):**
  - State IDLE, PC=START_ADDR, IR=0.
  - All outputs 0, except `instr_addr`, which equals START_ADDR.
- **Reset mid-operation:** reset dominates in any state, including WAIT and WB. No `wb_en` is asserted in the reset cycle.

## Timing
- FETCH→DECODE: one cycle. The ROM has one cycle of read latency.
- Minimum instruction latency for opcodes 0001–0100 is 6 cycles (FETCH, DECODE, READ, ISSUE, WB, next FETCH) when the trigger arrives in ISSUE. Opcode 0101 takes 5 cycles.
- `wb_en` is asserted in the cycle after the trigger is sampled.
- `busy` and `halted` are registered state decodes.

## Test plan
- **Basic multiply:** reset, ROM[0]=8'h26, regs B=3, C=5, `run`=1. Execution unit triggers 4 cycles after ISSUE with result 15.
  → `operand_a`=3, `operand_b`=5, `output_to_multicycle_opcode`=8'h26 during ISSUE/WAIT. Then `wb_en`=1 for one cycle with `wb_sel`=1 and `wb_data`=15, and PC=1.
- **Random / halt:** ROM[0]=8'h5A, ROM[1]=8'h00. Trigger in ISSUE with result 7.
  → operands 0, writeback to A with 7. Then HALT with `halted`=1, `error`=00, PC=1.
- **Illegal opcode:** ROM[0]=8'h9F.
  → HALT after DECODE, `error`=01. `output_to_multicycle_opcode` never nonzero, no `wb_en`.
- **Timeout:** MAX_WAIT=8, ROM[0]=8'h11, no trigger.
  → `error`=10 and HALT after 8 WAIT cycles, no `wb_en`. Then assert `reset`=0 for one cycle → IDLE, all error flags cleared.
- **Wrap and run:** ADDR_W=2, four legal instructions, `run` held high.
  → PC sequence 0,1,2,3,0. Drop `run` during WAIT of ROM[1] → ROM[1] completes with writeback, then IDLE with PC=2.
- **Reset mid-WAIT:** pull `reset` low while in WAIT, with the trigger asserted in the same cycle.
  → IDLE next cycle, `wb_en`=0, PC=START_ADDR.
